dwt53_lift_1d: RTL and testbench
================================

Name: dwt53_lift_1d

Overview:
- Streaming 1-D integer LeGall 5/3 lifting wavelet, forward direction, for the image-squash datapath.
- Successor to the fixed 8-bit, free-running, ROM-fed even/odd split stage. Adds:
  - parametrised sample width and line length;
  - valid/ready handshakes on input and output;
  - symmetric boundary extension at line ends;
  - a line-end marker on the output.
- Consumes one pixel row and emits LINE_LEN/2 (low, high) coefficient pairs to the next squash/sharpen stage.

Parameters:
- DATA_W, 8, input pixel width, unsigned.
- COEF_W, 10, output coefficient width, signed two's complement. Must be >= DATA_W+2; elaboration error otherwise.
- LINE_LEN, 64, samples per line. Must be even and >= 4; elaboration error otherwise.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  pixel sample x[k], unsigned.
- out_valid  out  1  coefficient pair is valid.
- out_ready  in  1  downstream accepts the pair.
- out_low  out  COEF_W  low-band coefficient s[n], signed.
- out_high  out  COEF_W  high-band coefficient d[n], signed, sign-extended.
- out_last  out  1  high on the final pair of a line.

Behaviour:
- Reset:
  - clk and rst only; the reset is synchronous and active-high.
  - On reset: out_valid=0, out_low=0, out_high=0, out_last=0, sample index=0, state=EVEN, internal x/d history=0.
  - in_ready is 1 after reset.
  - Reset asserted mid-line discards the partial line. The next accepted sample is x[0] of a new line.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, which gives a single output register and full throughput.
  - Outputs hold stable while out_valid && !out_ready.
- Lifting arithmetic (floor = arithmetic shift right):
  - Predict: d[n] = x[2n+1] - floor((x[2n]+x[2n+2])/2).
  - Update: s[n] = x[2n] + floor((d[n-1]+d[n]+2)/4).
- Boundary extension:
  - Left edge: d[-1] = d[0].
  - Right edge: x[LINE_LEN] = x[LINE_LEN-2], so d[last] = x[LINE_LEN-1] - x[LINE_LEN-2].
- Intermediate widths: internal sums use DATA_W+3 bits signed, so no wrap is possible. d fits in DATA_W+1 bits and s fits in DATA_W+2 bits.
- State machine:
  - EVEN: waiting for an even sample.
  - ODD: waiting for an odd sample.
  - Every accepted sample toggles the state.
  - The index counter counts 0..LINE_LEN-1 and wraps to 0 after the last sample.
- Emission:
  - Accepting even sample x[2n+2] (n >= 0) loads pair n into the output register. out_valid=1 on the next cycle.
  - x[0] emits nothing; the odd samples x[1]..x[LINE_LEN-3] emit nothing.
  - Accepting x[LINE_LEN-1] loads the final pair LINE_LEN/2-1 with out_last=1. No flush cycle is needed.
  - A new line can start the next cycle after x[LINE_LEN-1] is accepted.
- Latency: 1 cycle from the triggering input handshake to out_valid.
- Simultaneous events:
  - An output transfer and a new load in the same cycle: the new pair replaces the old one, and out_valid stays 1.
  - rst has priority over both handshakes.

Optional Feature:
- Macro DWT53_DEADZONE_EN.
- When defined:
  - Adds parameter DZ_THRESH (default 4).
  - Adds output zero_cnt (16 bits): the count of zeroed high coefficients in the current line.
  - Any d with |d| < DZ_THRESH is output as out_high=0. Unquantised d is still used for the s update.
  - zero_cnt clears on rst and on the first emission of each line, and saturates at 16'hFFFF.
- When undefined: no extra port or parameter; out_high = d exactly.

Decomposition:
- Package dwt_pkg:
  - COEF_W derivation helper (DATA_W+2);
  - state enum {EVEN, ODD};
  - functions predict() and update() with explicit floor semantics.
- Sub-module dwt53_lift_core (combinational):
  - inputs: x_even_prev, x_odd, x_even_next, d_prev, and an edge flag;
  - outputs: d and s.
- Top level holds the handshake, counter, history registers and output register.

Test Plan:
- LINE_LEN=64, x = 145, 56, 49, 89, 137 -> pair0 (s=125, d=-41) after x2; pair1 (s=38, d=-4) after x4. Checks floor on the negative value -43/4 = -11.
- LINE_LEN=4, x = 145, 56, 49, 89 -> (125, -41), then (49, 40) with out_last=1; exactly 2 output pairs.
- Constant line, all 100 -> every pair (100, 0); out_last only on pair 31.
- Extremes x = 0, 255, 0, ... -> d0=255, s0=128; no overflow at COEF_W=10.
- out_ready held 0 for 5 cycles mid-line -> in_ready=0, outputs stable, no sample lost; full rate resumes when out_ready returns.
- rst pulsed after x[7] -> out_valid=0. Next line 145, 56, 49 reproduces (125, -41).
- With DWT53_DEADZONE_EN, DZ_THRESH=5 -> pair1 d=-4 output as 0, s1 still 38, zero_cnt=1.

Source files
------------

// File: rtl/dwt_pkg.sv
// Purpose  : shared types and lifting arithmetic for the 5/3 forward wavelet stage.
// Latency  : n/a (package; pure functions only).
// Backpres.: n/a.
// Contents : coef_w() width helper, state_e {EVEN, ODD}, predict()/update() with
//            floor division implemented as arithmetic right shift.
package dwt_pkg;

    // Lifting math is evaluated at this width. Inputs are at most DATA_W+3 bits
    // signed, so any DATA_W up to 28 can never wrap here.
    localparam int LIFT_W = 32;

    typedef logic signed [LIFT_W-1:0] lift_t;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_e;

    // Minimum signed coefficient width that holds s[n] without overflow.
    function automatic int coef_w(input int data_w);
        return data_w + 2;
    endfunction

    // d[n] = x[2n+1] - floor((x[2n] + x[2n+2]) / 2)
    function automatic lift_t predict(input lift_t xe0, input lift_t xo, input lift_t xe1);
        return xo - ((xe0 + xe1) >>> 1);
    endfunction

    // s[n] = x[2n] + floor((d[n-1] + d[n] + 2) / 4)
    function automatic lift_t update(input lift_t xe, input lift_t dp, input lift_t dn);
        return xe + ((dp + dn + lift_t'(2)) >>> 2);
    endfunction

endpackage

// File: rtl/dwt53_lift_core.sv
// Purpose  : combinational predict + update for one (s, d) coefficient pair.
// Latency  : 0 cycles (pure combinational).
// Backpres.: none; the caller decides when the result is captured.
// Ports    : x_even_prev_i/x_odd_i/x_even_next_i unsigned samples x[2n], x[2n+1], x[2n+2];
//            d_prev_i = d[n-1]; first_i selects the left-edge rule d[-1] = d[0];
//            d_o = d[n] (DATA_W+1 signed), s_o = s[n] (DATA_W+2 signed).
module dwt53_lift_core
    import dwt_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic        [DATA_W-1:0] x_even_prev_i,
    input  logic        [DATA_W-1:0] x_odd_i,
    input  logic        [DATA_W-1:0] x_even_next_i,
    input  logic signed [DATA_W:0]   d_prev_i,
    input  logic                     first_i,
    output logic signed [DATA_W:0]   d_o,
    output logic signed [DATA_W+1:0] s_o
);

    lift_t xe0_w, xo_w, xe1_w, dp_w, d_w, s_w;

    always_comb begin
        // Samples are unsigned: the size cast zero-extends them.
        xe0_w = lift_t'(x_even_prev_i);
        xo_w  = lift_t'(x_odd_i);
        xe1_w = lift_t'(x_even_next_i);
        d_w   = predict(xe0_w, xo_w, xe1_w);
        // First pair of a line mirrors d[0] in place of the missing d[-1].
        dp_w  = first_i ? d_w : lift_t'(d_prev_i);
        s_w   = update(xe0_w, dp_w, d_w);
        d_o   = (DATA_W+1)'(d_w);
        s_o   = (DATA_W+2)'(s_w);
    end

endmodule

// File: rtl/dwt53_lift_1d.sv
// Purpose  : streaming 1-D LeGall 5/3 forward lifting, one (low, high) pair per even sample.
// Latency  : 1 cycle from the triggering input handshake to out_valid.
// Backpres.: single output register; in_ready = !out_valid || out_ready, outputs hold while stalled.
// Ports    : clk/rst (sync, active-high); in_valid/in_ready/in_data pixel stream;
//            out_valid/out_ready/out_low/out_high/out_last coefficient stream.
// Option   : DWT53_DEADZONE_EN adds DZ_THRESH and zero_cnt; |d| < DZ_THRESH is output as 0.
module dwt53_lift_1d
    import dwt_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 10,
    parameter int LINE_LEN = 64
`ifdef DWT53_DEADZONE_EN
    ,
    parameter int DZ_THRESH = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_low,
    output logic signed [COEF_W-1:0] out_high,
    output logic                     out_last
`ifdef DWT53_DEADZONE_EN
    ,
    output logic        [15:0]       zero_cnt
`endif
);

    localparam int                IDX_W    = $clog2(LINE_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_TWO  = IDX_W'(2);

    if (COEF_W < coef_w(DATA_W)) begin : g_chk_coef
        $error("dwt53_lift_1d: COEF_W must be >= DATA_W+2");
    end
    if ((LINE_LEN % 2) != 0 || LINE_LEN < 4) begin : g_chk_len
        $error("dwt53_lift_1d: LINE_LEN must be even and >= 4");
    end
    if (DATA_W > LIFT_W - 4) begin : g_chk_data
        $error("dwt53_lift_1d: DATA_W too wide for the lifting datapath");
    end

    // State and history
    state_e                    state_q, state_d;
    logic        [IDX_W-1:0]   idx_q, idx_d;
    logic        [DATA_W-1:0]  x_even_q, x_even_d;
    logic        [DATA_W-1:0]  x_odd_q, x_odd_d;
    logic signed [DATA_W:0]    d_prev_q, d_prev_d;
    // Output register
    logic                      out_valid_q, out_valid_d;
    logic signed [COEF_W-1:0]  out_low_q, out_low_d;
    logic signed [COEF_W-1:0]  out_high_q, out_high_d;
    logic                      out_last_q, out_last_d;

    logic                      accept, even_load, last_load, load, first;
    logic        [DATA_W-1:0]  core_xo, core_xn;
    logic signed [DATA_W:0]    core_d, high_sel;
    logic signed [DATA_W+1:0]  core_s;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign first     = (idx_q == IDX_TWO);
    // x[0] emits nothing; every later even sample closes pair (idx/2 - 1).
    assign even_load = accept && (state_q == EVEN) && (idx_q != '0);
    // The last odd sample closes the final pair using the mirrored x[LINE_LEN-2].
    assign last_load = accept && (state_q == ODD) && (idx_q == IDX_LAST);
    assign load      = even_load || last_load;

    // On the final odd sample the odd value is still on in_data and the
    // right neighbour is the mirror x[LINE_LEN] = x[LINE_LEN-2].
    assign core_xo = (state_q == ODD) ? in_data  : x_odd_q;
    assign core_xn = (state_q == ODD) ? x_even_q : in_data;

    dwt53_lift_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .x_even_prev_i (x_even_q),
        .x_odd_i       (core_xo),
        .x_even_next_i (core_xn),
        .d_prev_i      (d_prev_q),
        .first_i       (first),
        .d_o           (core_d),
        .s_o           (core_s)
    );

`ifdef DWT53_DEADZONE_EN
    logic        dz_hit;
    logic [15:0] zero_cnt_q, zero_cnt_d;

    assign dz_hit   = (core_d < DZ_THRESH) && (core_d > -DZ_THRESH);
    // Only the emitted high band is quantised; d_prev keeps the exact value.
    assign high_sel = dz_hit ? '0 : core_d;
    assign zero_cnt = zero_cnt_q;
`else
    assign high_sel = core_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_even_d    = x_even_q;
        x_odd_d     = x_odd_q;
        d_prev_d    = d_prev_q;
        out_valid_d = out_valid_q;
        out_low_d   = out_low_q;
        out_high_d  = out_high_q;
        out_last_d  = out_last_q;
`ifdef DWT53_DEADZONE_EN
        zero_cnt_d  = zero_cnt_q;
`endif

        if (accept) begin
            state_d = (state_q == EVEN) ? ODD : EVEN;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            if (state_q == EVEN) begin
                x_even_d = in_data;
                if (idx_q != '0) begin
                    d_prev_d = core_d;
                end
            end else begin
                x_odd_d = in_data;
            end
        end

        // A new load wins over a simultaneous output transfer.
        if (load) begin
            out_valid_d = 1'b1;
            out_low_d   = COEF_W'(core_s);
            out_high_d  = COEF_W'(high_sel);
            out_last_d  = last_load;
`ifdef DWT53_DEADZONE_EN
            if (even_load && first) begin
                zero_cnt_d = dz_hit ? 16'd1 : 16'd0;
            end else if (dz_hit && (zero_cnt_q != 16'hFFFF)) begin
                zero_cnt_d = zero_cnt_q + 16'd1;
            end
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EVEN;
            idx_q       <= '0;
            x_even_q    <= '0;
            x_odd_q     <= '0;
            d_prev_q    <= '0;
            out_valid_q <= 1'b0;
            out_low_q   <= '0;
            out_high_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef DWT53_DEADZONE_EN
            zero_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_even_q    <= x_even_d;
            x_odd_q     <= x_odd_d;
            d_prev_q    <= d_prev_d;
            out_valid_q <= out_valid_d;
            out_low_q   <= out_low_d;
            out_high_q  <= out_high_d;
            out_last_q  <= out_last_d;
`ifdef DWT53_DEADZONE_EN
            zero_cnt_q  <= zero_cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_low   = out_low_q;
    assign out_high  = out_high_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_dwt53_lift_1d.sv
// Purpose  : scoreboard bench for dwt53_lift_1d; u_a runs LINE_LEN=64, u_b runs LINE_LEN=4.
// Latency  : expected pairs are queued when the triggering sample is driven, popped on transfer.
// Backpres.: out_ready is driven by the bench, including a 5-cycle stall mid-line.
module tb_dwt53_lift_1d;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
    logic        [7:0] in_data_a;
    logic signed [9:0] out_low_a, out_high_a;
    logic              in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
    logic        [7:0] in_data_b;
    logic signed [9:0] out_low_b, out_high_b;
`ifdef DWT53_DEADZONE_EN
    logic [15:0] zc_a, zc_b;
`endif

    dwt53_lift_1d #(
        .DATA_W (8), .COEF_W (10), .LINE_LEN (64)
`ifdef DWT53_DEADZONE_EN
        , .DZ_THRESH (5)
`endif
    ) u_a (
        .clk (clk), .rst (rst),
        .in_valid (in_valid_a), .in_ready (in_ready_a), .in_data (in_data_a),
        .out_valid (out_valid_a), .out_ready (out_ready_a),
        .out_low (out_low_a), .out_high (out_high_a), .out_last (out_last_a)
`ifdef DWT53_DEADZONE_EN
        , .zero_cnt (zc_a)
`endif
    );

    dwt53_lift_1d #(
        .DATA_W (8), .COEF_W (10), .LINE_LEN (4)
`ifdef DWT53_DEADZONE_EN
        , .DZ_THRESH (5)
`endif
    ) u_b (
        .clk (clk), .rst (rst),
        .in_valid (in_valid_b), .in_ready (in_ready_b), .in_data (in_data_b),
        .out_valid (out_valid_b), .out_ready (out_ready_b),
        .out_low (out_low_b), .out_high (out_high_b), .out_last (out_last_b)
`ifdef DWT53_DEADZONE_EN
        , .zero_cnt (zc_b)
`endif
    );

    typedef struct {
        int lo;
        int hi;
        bit last;
        int zc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   pops_a = 0;
    int   pops_b = 0;
    int   cyc    = 0;
    int   zexp_a = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dz(input int h);
`ifdef DWT53_DEADZONE_EN
        return (h < 5 && h > -5) ? 0 : h;
`else
        return h;
`endif
    endfunction

    // Drive one sample into DUT a (sel=0) or b (sel=1); optionally queue the pair it completes.
    task automatic send(input bit sel, input int x, input bit push, input bit first,
                        input int lo, input int hi, input bit last);
        exp_t e;
        bit   rdy;
        int   waited;
        waited = 0;
        e.lo   = lo;
        e.hi   = dz(hi);
        e.last = last;
        e.zc   = 0;
        if (push) begin
            if (!sel) begin
                if (first) zexp_a = (e.hi == 0) ? 1 : 0;
                else if (e.hi == 0) zexp_a++;
                e.zc = zexp_a;
                q_a.push_back(e);
            end else begin
                q_b.push_back(e);
            end
        end
        if (!sel) begin
            in_valid_a = 1'b1;
            in_data_a  = x[7:0];
        end else begin
            in_valid_b = 1'b1;
            in_data_b  = x[7:0];
        end
        while (1) begin
            @(negedge clk);
            rdy = sel ? in_ready_b : in_ready_a;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: sample %0d not accepted, got 0, expected 1", x);
                break;
            end
        end
        if (!sel) in_valid_a = 1'b0;
        else      in_valid_b = 1'b0;
    endtask

    // Monitors: compare every output transfer against the head of the queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected: got pair (%0d,%0d), expected none", out_low_a, out_high_a);
            end else begin
                e = q_a.pop_front();
                check("a_low", out_low_a, e.lo);
                check("a_high", out_high_a, e.hi);
                check("a_last", int'(out_last_a), int'(e.last));
`ifdef DWT53_DEADZONE_EN
                check("a_zero_cnt", int'(zc_a), e.zc);
`endif
                pops_a++;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected: got pair (%0d,%0d), expected none", out_low_b, out_high_b);
            end else begin
                e = q_b.pop_front();
                check("b_low", out_low_b, e.lo);
                check("b_high", out_high_b, e.hi);
                check("b_last", int'(out_last_b), int'(e.last));
                pops_b++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, waited;
        rst = 1'b1;
        in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_out_low", out_low_a, 0);
        check("rst_out_high", out_high_a, 0);
        check("rst_out_last", int'(out_last_a), 0);
        check("rst_in_ready", int'(in_ready_a), 1);
        check("rst_b_out_valid", int'(out_valid_b), 0);
        @(posedge clk);
        #1;

        // Line start: pairs 0..2, incl. floor(-43/4) = -11 on pair 1
        send(0, 145, 0, 0, 0, 0, 0);
        send(0, 56,  0, 0, 0, 0, 0);
        send(0, 49,  1, 1, 125, -41, 0);
        send(0, 89,  0, 0, 0, 0, 0);
        send(0, 137, 1, 0, 38, -4, 0);
        send(0, 56,  0, 0, 0, 0, 0);
        send(0, 49,  1, 0, 127, -37, 0);
        send(0, 89,  0, 0, 0, 0, 0);

        // Hold a pending pair behind out_ready=0, then reset mid-line: it must vanish.
        out_ready_a = 1'b0;
        send(0, 200, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid_a), 0);
        check("midrst_in_ready", int'(in_ready_a), 1);
        check("midrst_out_low", out_low_a, 0);
        @(posedge clk);
        #1 out_ready_a = 1'b1;

        // Fresh line after reset reproduces pair 0
        send(0, 145, 0, 0, 0, 0, 0);
        send(0, 56,  0, 0, 0, 0, 0);
        send(0, 49,  1, 1, 125, -41, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Constant line with a 5-cycle output stall after pair 10
        t0 = 0;
        for (int k = 0; k < 64; k++) begin
            if (k == 23) begin
                out_ready_a = 1'b0;
                in_valid_a  = 1'b1;
                in_data_a   = 8'd100;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(in_ready_a), 0);
                    check("stall_out_valid", int'(out_valid_a), 1);
                    check("stall_out_low", out_low_a, 100);
                    check("stall_out_high", out_high_a, 0);
                    @(posedge clk);
                    #1;
                end
                out_ready_a = 1'b1;
                t0 = cyc;
            end
            send(0, 100, (k >= 2 && k % 2 == 0) || k == 63, k == 2, 100, 0, k == 63);
        end
        t1 = cyc;
        check("resume_full_rate_cycles", t1 - t0, 41);

        // Extremes 0,255,...: every pair (128, 255)
        for (int k = 0; k < 64; k++) begin
            send(0, (k % 2 == 0) ? 0 : 255, (k >= 2 && k % 2 == 0) || k == 63, k == 2,
                 128, 255, k == 63);
        end

        // LINE_LEN=4, two back-to-back lines
        for (int l = 0; l < 2; l++) begin
            send(1, 145, 0, 0, 0, 0, 0);
            send(1, 56,  0, 0, 0, 0, 0);
            send(1, 49,  1, 1, 125, -41, 0);
            send(1, 89,  1, 0, 49, 40, 1);
        end

        waited = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        check("a_pair_count", pops_a, 68);
        check("b_pair_count", pops_b, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
